// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state type and width default for counter_ctrl
package counter_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - command/status bundle between a controller host and counter_ctrl
// Commands (host -> counter): start, stop, clear, load, load_val, limit, periodic
// Status   (counter -> host): q, busy, done, cnt_en
interface counter_ctrl_if
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             periodic;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             cnt_en;

  modport master (
    output start, stop, clear, load, load_val, limit, periodic,
    input  q, busy, done, cnt_en
  );

  modport slave (
    input  start, stop, clear, load, load_val, limit, periodic,
    output q, busy, done, cnt_en
  );

endinterface

// File: rtl/cnt_core.sv
// rtl/cnt_core.sv - count register with sync clear, sync load and wrap-around increment
// clk      : clock
// reset    : synchronous active-low reset, q returns to 0
// i_en     : increment by one this cycle
// i_clr    : force q to 0 (wins over load and increment)
// i_ld     : load q from i_ld_val (wins over increment)
// i_ld_val : preset value
// o_q      : current count
module cnt_core
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  output logic [WIDTH-1:0] o_q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_ld_val;
    end else if (i_en) begin
      r_q <= r_q + ONE;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run/pause/done controller around a wrap-around up counter
// clk   : clock, all state updates on the rising edge
// reset : synchronous active-low reset
// bus   : counter_ctrl_if slave; commands in, q/busy/done/cnt_en out
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  counter_ctrl_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done;
  logic             w_clr;
  logic             w_ld;
  logic             w_en;
  logic             w_term;
  logic [WIDTH-1:0] w_q;

  cnt_core #(.WIDTH(WIDTH)) u_cnt_core (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_en),
    .i_clr    (w_clr),
    .i_ld     (w_ld),
    .i_ld_val (bus.load_val),
    .o_q      (w_q)
  );

  // limit is compared live every cycle, so a mid-run change applies immediately
  assign w_term = (r_state == RUN) && (w_q == bus.limit);

  // Command priority is clear > stop > load > start; the one exception is
  // load+start in IDLE, where both take effect.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_ld        = 1'b0;
    w_en        = 1'b0;
    if (bus.clear) begin
      w_clr       = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.stop) begin
            if (bus.load) w_ld = 1'b1;
            if (bus.start) w_state_nxt = RUN;
          end
        end
        RUN: begin
          // terminal count still fires done when stop arrives the same
          // cycle, but stop decides where the FSM goes
          if (w_term) begin
            if (bus.stop) w_state_nxt = PAUSE;
            else if (bus.periodic) w_clr = 1'b1;
            else w_state_nxt = DONE;
          end else if (bus.stop) begin
            w_state_nxt = PAUSE;
          end else begin
            w_en = 1'b1;
          end
        end
        PAUSE: begin
          if (bus.stop) w_state_nxt = IDLE;
          else if (bus.load) w_ld = 1'b1;
          else if (bus.start) w_state_nxt = RUN;
        end
        DONE: begin
          if (bus.stop) begin
            w_state_nxt = IDLE;
          end else if (bus.load) begin
            w_ld        = 1'b1;
            w_state_nxt = IDLE;
          end else if (bus.start) begin
            w_clr       = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_term & ~bus.clear;
    end
  end

  assign bus.q      = w_q;
  assign bus.done   = r_done;
  assign bus.busy   = (r_state == RUN) || (r_state == PAUSE);
  assign bus.cnt_en = (r_state == RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  counter_ctrl_if #(.WIDTH(32)) bus ();

  counter_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  int          m_mode;
  logic [31:0] m_q;
  logic        m_done;

  // Reference: apply the single winning command to the current mode.
  task automatic model_step();
    int cmd;
    bit term;
    term = (m_mode == M_RUN) && (m_q == bus.limit);
    if (!reset) begin
      m_mode = M_IDLE;
      m_q    = 0;
      m_done = 0;
      return;
    end
    m_done = term && !bus.clear;
    cmd = bus.clear ? 4 : bus.stop ? 3 : bus.load ? 2 : bus.start ? 1 : 0;
    if (cmd == 4) begin
      m_mode = M_IDLE;
      m_q    = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (cmd == 2) m_q = bus.load_val;
          if (cmd != 3 && bus.start) m_mode = M_RUN;
        end
        M_RUN: begin
          if (cmd == 3) m_mode = M_PAUSE;
          else if (term && bus.periodic) m_q = 0;
          else if (term) m_mode = M_DONE;
          else m_q = m_q + 1;
        end
        M_PAUSE: begin
          if (cmd == 3) m_mode = M_IDLE;
          else if (cmd == 2) m_q = bus.load_val;
          else if (cmd == 1) m_mode = M_RUN;
        end
        default: begin
          if (cmd == 3) m_mode = M_IDLE;
          else if (cmd == 2) begin m_q = bus.load_val; m_mode = M_IDLE; end
          else if (cmd == 1) begin m_q = 0; m_mode = M_RUN; end
        end
      endcase
    end
  endtask

  task automatic clr_cmds();
    bus.start = 0;
    bus.stop  = 0;
    bus.clear = 0;
    bus.load  = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr_cmds();
    bus.clear = 1;
    tick();
    bus.clear = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    bus.start = 1; bus.load = 1; bus.load_val = 32'h55; bus.limit = 0;
    repeat (3) tick();
    reset = 1;
    clr_cmds();
    checks++;
    if (bus.q !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: q=%0h busy=%b done=%b cnt_en=%b expected 0/0/0/0",
               bus.q, bus.busy, bus.done, bus.cnt_en);
    end
  endtask

  task automatic test_oneshot();
    bus.limit = 5; bus.periodic = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (bus.q !== 32'(i) || bus.done !== 1'b0 || bus.cnt_en !== 1'b1) begin
        failures++;
        $display("FAIL oneshot_count: q=%0d done=%b cnt_en=%b expected q=%0d done=0 cnt_en=1",
                 bus.q, bus.done, bus.cnt_en, i);
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.q !== 32'd5 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_done: done=%b q=%0d busy=%b expected 1/5/0", bus.done, bus.q, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.q !== 32'd5) begin
      failures++;
      $display("FAIL oneshot_hold: done=%b q=%0d expected 0/5", bus.done, bus.q);
    end
  endtask

  task automatic test_periodic();
    do_clear();
    bus.limit = 3; bus.periodic = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (bus.q !== 32'(i % 4) || bus.done !== ((i % 4 == 0) && i > 0) || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL periodic_seq: step=%0d q=%0d done=%b busy=%b expected q=%0d done=%b busy=1",
                 i, bus.q, bus.done, bus.busy, i % 4, (i % 4 == 0) && i > 0);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q [4];
    exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    do_clear();
    bus.load_val = 32'hFFFF_FFFE; bus.limit = 1; bus.periodic = 0;
    bus.load = 1; bus.start = 1;
    tick();
    clr_cmds();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.q !== exp_q[i] || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL wrap_seq: q=%0h done=%b expected q=%0h done=0", bus.q, bus.done, exp_q[i]);
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.q !== 32'd1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_done: done=%b q=%0h busy=%b expected 1/1/0", bus.done, bus.q, bus.busy);
    end
  endtask

  task automatic test_pause();
    do_clear();
    bus.load_val = 10; bus.limit = 1000; bus.periodic = 0;
    bus.load = 1; bus.start = 1;
    tick();
    clr_cmds();
    tick();
    tick();
    bus.stop = 1;
    tick();
    bus.stop = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.q !== 32'd12 || bus.cnt_en !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold: q=%0d cnt_en=%b busy=%b expected 12/0/1", bus.q, bus.cnt_en, bus.busy);
      end
      tick();
    end
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.q !== 32'(12 + i) || bus.cnt_en !== 1'b1) begin
        failures++;
        $display("FAIL pause_resume: q=%0d cnt_en=%b expected q=%0d cnt_en=1", bus.q, bus.cnt_en, 12 + i);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    bus.load_val = 7; bus.limit = 100; bus.periodic = 0;
    bus.load = 1; bus.start = 1;
    tick();
    clr_cmds();
    reset = 0;
    tick();
    reset = 1;
    checks++;
    if (bus.q !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: q=%0d busy=%b done=%b expected 0/0/0", bus.q, bus.busy, bus.done);
    end
    bus.load_val = 4; bus.limit = 4;
    bus.load = 1; bus.start = 1;
    tick();
    clr_cmds();
    reset = 0;
    tick();
    reset = 1;
    checks++;
    if (bus.done !== 1'b0 || bus.q !== 32'd0) begin
      failures++;
      $display("FAIL reset_at_terminal: done=%b q=%0d expected 0/0", bus.done, bus.q);
    end
    bus.load_val = 7; bus.limit = 100;
    bus.load = 1; bus.start = 1;
    tick();
    clr_cmds();
    bus.clear = 1; bus.start = 1;
    tick();
    clr_cmds();
    checks++;
    if (bus.q !== 32'd0 || bus.busy !== 1'b0 || bus.cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL clear_beats_start: q=%0d busy=%b cnt_en=%b expected 0/0/0", bus.q, bus.busy, bus.cnt_en);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    bus.limit = 0; bus.periodic = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.q !== 32'd0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back: done=%b q=%0d busy=%b expected 1/0/1", bus.done, bus.q, bus.busy);
      end
    end
    do_clear();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      bus.clear    = ($urandom_range(0, 63) == 0);
      bus.stop     = ($urandom_range(0, 19) == 0);
      bus.load     = ($urandom_range(0, 15) == 0);
      bus.start    = ($urandom_range(0, 5) == 0);
      reset        = ($urandom_range(0, 199) != 0);
      bus.load_val = $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) bus.limit = $urandom_range(0, 20);
      if ($urandom_range(0, 49) == 0) bus.periodic = ~bus.periodic;
      tick();
      checks++;
      if (bus.q !== m_q || bus.done !== m_done ||
          bus.busy !== (m_mode == M_RUN || m_mode == M_PAUSE) ||
          bus.cnt_en !== (m_mode == M_RUN)) begin
        failures++;
        $display("FAIL random_step %0d: q=%0h done=%b busy=%b cnt_en=%b expected q=%0h done=%b mode=%0d",
                 n, bus.q, bus.done, bus.busy, bus.cnt_en, m_q, m_done, m_mode);
      end
    end
    reset = 1;
    clr_cmds();
  endtask

  initial begin
    reset = 0;
    clr_cmds();
    bus.load_val = 0;
    bus.limit    = 0;
    bus.periodic = 0;
    m_mode = M_IDLE;
    m_q    = 0;
    m_done = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_pause();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
